// File: rtl/cc_psr_flags_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cc_psr_flags_pkg
// Purpose  : Shared branch-condition codes, PSR bit positions and buffer
//            state encoding for the condition-code stage and control unit.
// Revision : 1.0
// ============================================================================
package cc_psr_flags_pkg;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;

    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_V = 1;
    localparam int PSR_C = 0;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } bufState_t;

    // ALU presents flags active-low; the PSR stores them active-high.
    function automatic logic [3:0] flagsFromAlu(
        input logic negLow,
        input logic zeroLow,
        input logic ovfLow,
        input logic carryLow
    );
        logic [3:0] flags;
        flags        = 4'b0000;
        flags[PSR_N] = ~negLow;
        flags[PSR_Z] = ~zeroLow;
        flags[PSR_V] = ~ovfLow;
        flags[PSR_C] = ~carryLow;
        return flags;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_branch_eval.sv
`default_nettype none
// ============================================================================
// Module   : cc_branch_eval
// Purpose  : Combinational ARC branch-condition evaluation against a PSR.
// Revision : 1.0
// ============================================================================
module cc_branch_eval
    import cc_psr_flags_pkg::*;
#(
    parameter int DATAWIDTH_COND = 4
) (
    input  logic [3:0]                i_psr,
    input  logic [DATAWIDTH_COND-1:0] i_cond,
    output logic                      o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_BN:   o_taken = 1'b0;
            COND_BE:   o_taken = i_psr[PSR_Z];
            COND_BCS:  o_taken = i_psr[PSR_C];
            COND_BNEG: o_taken = i_psr[PSR_N];
            COND_BVS:  o_taken = i_psr[PSR_V];
            COND_BA:   o_taken = 1'b1;
            default:   o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cc_psr_flags.sv
`default_nettype none
// ============================================================================
// Module   : cc_psr_flags
// Purpose  : Post-ALU stage: one-entry result buffer, registered active-high
//            PSR and branch-condition evaluation from the stored flags.
// Revision : 1.0
// ============================================================================
module cc_psr_flags
    import cc_psr_flags_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4
) (
    input  logic                      CC_PSR_CLOCK_50,
    input  logic                      CC_PSR_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_InBUS,
    input  logic                      CC_PSR_overflow_InLow,
    input  logic                      CC_PSR_carry_InLow,
    input  logic                      CC_PSR_negative_InLow,
    input  logic                      CC_PSR_zero_InLow,
    input  logic                      CC_PSR_setcc_In,
    input  logic                      CC_PSR_valid_In,
    output logic                      CC_PSR_ready_Out,
    output logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_OutBUS,
    output logic                      CC_PSR_valid_Out,
    input  logic                      CC_PSR_ready_In,
    input  logic                      CC_PSR_psrwrite_In,
    input  logic [3:0]                CC_PSR_psrwdata_InBUS,
    output logic [3:0]                CC_PSR_flags_OutBUS,
    input  logic [DATAWIDTH_COND-1:0] CC_PSR_cond_InBUS,
    output logic                      CC_PSR_taken_Out
);

    bufState_t                r_state;
    bufState_t                w_nextState;
    logic [DATAWIDTH_BUS-1:0] r_dataHold;
    logic [3:0]               r_psr;
    logic                     w_ready;
    logic                     w_accept;
    logic [3:0]               w_aluFlags;

    // Downstream ready passes straight through so a full buffer can stream.
    assign w_ready    = (r_state == ST_EMPTY) | CC_PSR_ready_In;
    assign w_accept   = CC_PSR_valid_In & w_ready;
    assign w_aluFlags = flagsFromAlu(CC_PSR_negative_InLow, CC_PSR_zero_InLow,
                                     CC_PSR_overflow_InLow, CC_PSR_carry_InLow);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_nextState = ST_FULL;
                end
            end
            ST_FULL: begin
                if (CC_PSR_ready_In && !w_accept) begin
                    w_nextState = ST_EMPTY;
                end
            end
            default: w_nextState = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            r_dataHold <= '0;
        end else if (w_accept) begin
            r_dataHold <= CC_PSR_data_InBUS;
        end
    end

    // An explicit PSR load (context restore) overrides a same-edge setcc update.
    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            r_psr <= 4'b0000;
        end else if (CC_PSR_psrwrite_In) begin
            r_psr <= CC_PSR_psrwdata_InBUS;
        end else if (w_accept && CC_PSR_setcc_In) begin
            r_psr <= w_aluFlags;
        end
    end

    cc_branch_eval #(
        .DATAWIDTH_COND (DATAWIDTH_COND)
    ) u_branchEval (
        .i_psr   (r_psr),
        .i_cond  (CC_PSR_cond_InBUS),
        .o_taken (CC_PSR_taken_Out)
    );

    assign CC_PSR_ready_Out    = w_ready;
    assign CC_PSR_valid_Out    = (r_state == ST_FULL);
    assign CC_PSR_data_OutBUS  = r_dataHold;
    assign CC_PSR_flags_OutBUS = r_psr;

endmodule
`default_nettype wire

// File: tb/tb_cc_psr_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_psr_flags
// Purpose  : Self-checking bench for cc_psr_flags against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cc_psr_flags;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] dataIn;
    logic        ovfLow, carryLow, negLow, zeroLow;
    logic        setcc, validIn, readyIn, psrWrite;
    logic [3:0]  psrWdata;
    logic [3:0]  cond;
    logic        readyOut, validOut, takenOut;
    logic [31:0] dataOut;
    logic [3:0]  flagsOut;

    int checks = 0;
    int errors = 0;

    bit          mFull;
    logic [31:0] mData;
    logic [3:0]  mPsr;

    always #5 clk = ~clk;

    cc_psr_flags #(
        .DATAWIDTH_BUS  (32),
        .DATAWIDTH_COND (4)
    ) dut (
        .CC_PSR_CLOCK_50       (clk),
        .CC_PSR_RESET_InLow    (rstN),
        .CC_PSR_data_InBUS     (dataIn),
        .CC_PSR_overflow_InLow (ovfLow),
        .CC_PSR_carry_InLow    (carryLow),
        .CC_PSR_negative_InLow (negLow),
        .CC_PSR_zero_InLow     (zeroLow),
        .CC_PSR_setcc_In       (setcc),
        .CC_PSR_valid_In       (validIn),
        .CC_PSR_ready_Out      (readyOut),
        .CC_PSR_data_OutBUS    (dataOut),
        .CC_PSR_valid_Out      (validOut),
        .CC_PSR_ready_In       (readyIn),
        .CC_PSR_psrwrite_In    (psrWrite),
        .CC_PSR_psrwdata_InBUS (psrWdata),
        .CC_PSR_flags_OutBUS   (flagsOut),
        .CC_PSR_cond_InBUS     (cond),
        .CC_PSR_taken_Out      (takenOut)
    );

    // Branch table by mnemonic; PSR is {N,Z,V,C}.
    function automatic logic expTaken(input logic [3:0] c, input logic [3:0] psr);
        logic n, z, v, cy;
        {n, z, v, cy} = psr;
        case (c)
            4'b0001: return z;
            4'b0101: return cy;
            4'b0110: return n;
            4'b0111: return v;
            4'b1000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic expReady();
        return !mFull || readyIn;
    endfunction

    task automatic modelReset();
        mFull = 1'b0;
        mData = 32'h0;
        mPsr  = 4'b0000;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit acc;
        acc = validIn && expReady();
        if (psrWrite)
            mPsr = psrWdata;
        else if (acc && setcc)
            mPsr = {~negLow, ~zeroLow, ~ovfLow, ~carryLow};
        if (acc)
            mData = dataIn;
        if (acc)
            mFull = 1'b1;
        else if (readyIn)
            mFull = 1'b0;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        dataIn = 32'h0; ovfLow = 1'b1; carryLow = 1'b1; negLow = 1'b1; zeroLow = 1'b1;
        setcc = 1'b0; validIn = 1'b0; readyIn = 1'b1; psrWrite = 1'b0; psrWdata = 4'h0;
    endtask

    task automatic test_reset();
        idleInputs();
        cond = 4'b1000;
        rstN = 1'b0;
        modelReset();
        #1;
        checks++; if (flagsOut !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flagsOut); end
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", validOut); end
        checks++; if (readyOut !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", readyOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", dataOut); end
        checks++; if (takenOut !== 1'b1) begin errors++; $display("FAIL reset_taken_ba got=%b exp=1", takenOut); end
        cond = 4'b0001;
        #1;
        checks++; if (takenOut !== 1'b0) begin errors++; $display("FAIL reset_taken_be got=%b exp=0", takenOut); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_setcc();
        idleInputs();
        validIn = 1'b1; dataIn = 32'h0; zeroLow = 1'b0; setcc = 1'b1; cond = 4'b0001;
        #1;
        checks++; if (takenOut !== 1'b0) begin errors++; $display("FAIL setcc_old_flags_taken got=%b exp=0", takenOut); end
        tick();
        idleInputs();
        readyIn = 1'b0;
        #1;
        checks++; if (flagsOut !== 4'b0100) begin errors++; $display("FAIL setcc_flags got=%b exp=0100", flagsOut); end
        checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL setcc_valid got=%b exp=1", validOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL setcc_data got=%h exp=0", dataOut); end
        checks++; if (takenOut !== 1'b1) begin errors++; $display("FAIL setcc_taken_be got=%b exp=1", takenOut); end
    endtask

    task automatic test_nosetcc();
        idleInputs();
        validIn = 1'b1; dataIn = 32'h0000_1234; carryLow = 1'b0; setcc = 1'b0; cond = 4'b0101;
        tick();
        idleInputs();
        readyIn = 1'b0;
        #1;
        checks++; if (flagsOut !== 4'b0100) begin errors++; $display("FAIL nosetcc_flags got=%b exp=0100", flagsOut); end
        checks++; if (takenOut !== 1'b0) begin errors++; $display("FAIL nosetcc_taken_bcs got=%b exp=0", takenOut); end
        checks++; if (dataOut !== 32'h0000_1234) begin errors++; $display("FAIL nosetcc_data got=%h exp=00001234", dataOut); end
    endtask

    task automatic test_backpressure();
        idleInputs();
        validIn = 1'b1; dataIn = 32'hDEAD_BEEF;
        tick();
        dataIn = 32'h0000_0001; readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (readyOut !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, readyOut); end
            tick();
            checks++; if (dataOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=deadbeef", i, dataOut); end
            checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, validOut); end
        end
        readyIn = 1'b1;
        #1;
        checks++; if (readyOut !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", readyOut); end
        tick();
        checks++; if (dataOut !== 32'h0000_0001) begin errors++; $display("FAIL bp_release_data got=%h exp=00000001", dataOut); end
        checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%b exp=1", validOut); end
        validIn = 1'b0;
        tick();
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%b exp=0", validOut); end
    endtask

    task automatic test_psrwrite_priority();
        idleInputs();
        validIn = 1'b1; setcc = 1'b1; ovfLow = 1'b0; dataIn = 32'h5555_AAAA;
        psrWrite = 1'b1; psrWdata = 4'b1010;
        tick();
        idleInputs();
        #1;
        checks++; if (flagsOut !== 4'b1010) begin errors++; $display("FAIL psrwrite_wins got=%b exp=1010", flagsOut); end
        checks++; if (dataOut !== 32'h5555_AAAA) begin errors++; $display("FAIL psrwrite_data got=%h exp=5555aaaa", dataOut); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            dataIn   = $urandom;
            {ovfLow, carryLow, negLow, zeroLow} = 4'($urandom);
            setcc    = 1'($urandom);
            validIn  = ($urandom_range(0, 3) != 0);
            readyIn  = ($urandom_range(0, 3) != 0);
            psrWrite = ($urandom_range(0, 7) == 0);
            psrWdata = 4'($urandom);
            cond     = 4'($urandom);
            #1;
            checks++; if (readyOut !== expReady()) begin errors++; $display("FAIL rnd_ready it=%0d got=%b exp=%b", i, readyOut, expReady()); end
            checks++; if (takenOut !== expTaken(cond, mPsr)) begin errors++; $display("FAIL rnd_taken it=%0d cond=%b got=%b exp=%b", i, cond, takenOut, expTaken(cond, mPsr)); end
            tick();
            checks++; if (validOut !== mFull) begin errors++; $display("FAIL rnd_valid it=%0d got=%b exp=%b", i, validOut, mFull); end
            checks++; if (flagsOut !== mPsr) begin errors++; $display("FAIL rnd_flags it=%0d got=%b exp=%b", i, flagsOut, mPsr); end
            if (mFull) begin
                checks++; if (dataOut !== mData) begin errors++; $display("FAIL rnd_data it=%0d got=%h exp=%h", i, dataOut, mData); end
            end
        end
    endtask

    task automatic test_async_reset();
        idleInputs();
        readyIn = 1'b1;
        tick();
        validIn = 1'b1; dataIn = 32'h0000_CAFE; readyIn = 1'b0;
        psrWrite = 1'b1; psrWdata = 4'b1111;
        tick();
        psrWrite = 1'b0; validIn = 1'b1; dataIn = 'x; setcc = 1'b1;
        zeroLow = 1'b0; negLow = 1'b0; ovfLow = 1'b0; carryLow = 1'b0;
        tick();
        checks++; if (flagsOut !== 4'b1111) begin errors++; $display("FAIL stall_x_flags got=%b exp=1111", flagsOut); end
        checks++; if (dataOut !== 32'h0000_CAFE) begin errors++; $display("FAIL stall_x_data got=%h exp=0000cafe", dataOut); end
        checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL stall_x_valid got=%b exp=1", validOut); end
        idleInputs();
        readyIn = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", validOut); end
        checks++; if (flagsOut !== 4'b0000) begin errors++; $display("FAIL async_rst_flags got=%b exp=0000", flagsOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL async_rst_data got=%h exp=0", dataOut); end
        checks++; if (readyOut !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", readyOut); end
        #2;
        rstN = 1'b1;
        modelReset();
        readyIn = 1'b1;
        tick();
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%b exp=0", validOut); end
    endtask

    initial begin
        test_reset();
        test_setcc();
        test_nosetcc();
        test_backpressure();
        test_psrwrite_priority();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
